// File: rtl/image_pkt_uart_tx.sv
// Drains 16-bit pixels from the image FIFO and frames them into UART byte packets:
// 0x55, 0xAA, pixel bytes MSB first, then an 8-bit additive checksum of the payload.
//
// state | meaning
// IDLE  | waiting for enable with FIFO data available
// HDR0  | send header byte 0x55
// HDR1  | send header byte 0xAA
// FETCH | pulse rd when FIFO has data; count starved cycles toward abort
// LATCH | capture fifoOut (one-cycle read latency)
// TX_HI | send pixel[15:8]
// TX_LO | send pixel[7:0]; choose next pixel or checksum
// CSUM  | send accumulated checksum
// DONE  | pulse pktDone
module image_pkt_uart_tx #(
  parameter int PIXELS_PER_PKT = 16,
  parameter int TIMEOUT_CYC    = 4000
) (
  input  logic        clk40M,
  input  logic        nRst,
  input  logic        enable,
  input  logic        empty,
  output logic        rd,
  input  logic [15:0] fifoOut,
  input  logic        txBusy,
  output logic        txStart,
  output logic [7:0]  txData,
  output logic        busy,
  output logic        pktDone,
  output logic        pktAbort
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [7:0]    PIX_LAST = 8'(PIXELS_PER_PKT - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, HDR0, HDR1, FETCH, LATCH, TX_HI, TX_LO, CSUM, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    pix_cnt, pix_cnt_nxt;
  logic [7:0]    csum, csum_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic [15:0]   pixel, pixel_nxt;
  logic          guard, guard_nxt;
  logic [7:0]    tx_data_nxt;
  logic          can_send;

  // guard is high exactly on the txStart cycle, so txBusy is ignored while the UART latches the byte
  assign can_send = !txBusy && !guard;
  assign txStart  = guard;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      state   <= IDLE;
      pix_cnt <= '0;
      csum    <= '0;
      to_cnt  <= '0;
      pixel   <= '0;
      guard   <= 1'b0;
      txData  <= '0;
    end else begin
      state   <= state_nxt;
      pix_cnt <= pix_cnt_nxt;
      csum    <= csum_nxt;
      to_cnt  <= to_cnt_nxt;
      pixel   <= pixel_nxt;
      guard   <= guard_nxt;
      txData  <= tx_data_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pix_cnt_nxt = pix_cnt;
    csum_nxt    = csum;
    to_cnt_nxt  = to_cnt;
    pixel_nxt   = pixel;
    guard_nxt   = 1'b0;
    tx_data_nxt = txData;
    rd          = 1'b0;
    pktDone     = 1'b0;
    pktAbort    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !empty) begin
          state_nxt   = HDR0;
          csum_nxt    = '0;
          pix_cnt_nxt = '0;
          to_cnt_nxt  = '0;
        end
      end
      HDR0: begin
        if (can_send) begin
          guard_nxt   = 1'b1;
          tx_data_nxt = 8'h55;
          state_nxt   = HDR1;
        end
      end
      HDR1: begin
        if (can_send) begin
          guard_nxt   = 1'b1;
          tx_data_nxt = 8'hAA;
          state_nxt   = FETCH;
        end
      end
      FETCH: begin
        if (!empty) begin
          rd         = 1'b1;
          to_cnt_nxt = '0;
          state_nxt  = LATCH;
        end else if (to_cnt == TO_LAST) begin
          pktAbort   = 1'b1;
          to_cnt_nxt = '0;
          state_nxt  = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      LATCH: begin
        pixel_nxt = fifoOut;
        state_nxt = TX_HI;
      end
      TX_HI: begin
        if (can_send) begin
          guard_nxt   = 1'b1;
          tx_data_nxt = pixel[15:8];
          csum_nxt    = csum + pixel[15:8];
          state_nxt   = TX_LO;
        end
      end
      TX_LO: begin
        if (can_send) begin
          guard_nxt   = 1'b1;
          tx_data_nxt = pixel[7:0];
          csum_nxt    = csum + pixel[7:0];
          if (pix_cnt == PIX_LAST) begin
            state_nxt = CSUM;
          end else begin
            pix_cnt_nxt = pix_cnt + 1'b1;
            state_nxt   = FETCH;
          end
        end
      end
      CSUM: begin
        if (can_send) begin
          guard_nxt   = 1'b1;
          tx_data_nxt = csum;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        pktDone   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_image_pkt_uart_tx.sv
// Directed bench for image_pkt_uart_tx with a FIFO model and a UART model that stays busy
// for 10 cycles per byte; every launched byte is logged and compared to hand-computed packets.
module tb_image_pkt_uart_tx;

  logic        clk40M = 1'b0;
  logic        nRst;
  logic        enable;
  logic        empty;
  logic        rd;
  logic [15:0] fifoOut;
  logic        txBusy;
  logic        txStart;
  logic [7:0]  txData;
  logic        busy;
  logic        pktDone;
  logic        pktAbort;

  image_pkt_uart_tx #(.PIXELS_PER_PKT(2), .TIMEOUT_CYC(50)) dut (
    .clk40M(clk40M), .nRst(nRst), .enable(enable), .empty(empty), .rd(rd),
    .fifoOut(fifoOut), .txBusy(txBusy), .txStart(txStart), .txData(txData),
    .busy(busy), .pktDone(pktDone), .pktAbort(pktAbort)
  );

  always #5 clk40M = ~clk40M;

  // FIFO model: data appears on fifoOut the cycle after rd
  logic [15:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign empty = (wr_ptr == rd_ptr);
  always @(posedge clk40M) begin
    if (rd) begin
      fifoOut <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  int   busy_cnt = 0;
  logic force_busy = 1'b0;
  assign txBusy = force_busy || (busy_cnt != 0);

  logic [7:0] byte_log [0:127];
  int n_bytes = 0, rd_count = 0, done_count = 0, abort_count = 0;
  int viol_busy = 0, viol_gap = 0, viol_rd = 0;
  int cyc = 0, last_start_cyc = 0, abort_cyc = 0;
  logic prev_start = 1'b0, prev_rd = 1'b0;

  always @(posedge clk40M) begin
    cyc <= cyc + 1;
    if (txStart) begin
      busy_cnt <= 10;
      if (n_bytes < 128) byte_log[n_bytes] <= txData;
      n_bytes <= n_bytes + 1;
      last_start_cyc <= cyc;
      if (txBusy) viol_busy <= viol_busy + 1;
      if (prev_start) viol_gap <= viol_gap + 1;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (rd) begin
      rd_count <= rd_count + 1;
      if (empty || prev_rd) viol_rd <= viol_rd + 1;
    end
    if (pktDone) done_count <= done_count + 1;
    if (pktAbort) begin
      abort_count <= abort_count + 1;
      abort_cyc   <= cyc;
    end
    prev_start <= txStart;
    prev_rd    <= rd;
  end

  int passed = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [15:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && done_count < target; i++) @(negedge clk40M);
    chk("done_count", done_count, target);
  endtask

  task automatic wait_bytes(input int target);
    for (int i = 0; i < 3000 && n_bytes < target; i++) @(negedge clk40M);
    chk("byte_wait", n_bytes >= target, 1);
  endtask

  task automatic check_pkt(input string tag, input int base, input int n, input logic [63:0] exp);
    chk({tag, "_len"}, n_bytes, base + n);
    for (int i = 0; i < n; i++)
      chk(tag, {24'd0, byte_log[base + i]}, {24'd0, exp[8*(n-1-i) +: 8]});
  endtask

  int base, held_nb, aborts_before;
  logic [7:0] held_data;

  initial begin
    nRst = 1'b1;
    enable = 1'b0;
    #2 nRst = 1'b0;
    repeat (3) @(negedge clk40M);
    chk("rst_txStart", txStart, 0);
    chk("rst_txData", txData, 0);
    chk("rst_rd", rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pktDone", pktDone, 0);
    chk("rst_pktAbort", pktAbort, 0);
    nRst = 1'b1;
    @(negedge clk40M);

    // minimal packet
    push(16'h1234);
    push(16'h00FF);
    enable = 1'b1;
    wait_done(1);
    enable = 1'b0;
    @(negedge clk40M);
    check_pkt("pkt1", 0, 7, 64'h0055AA123400FF45);
    chk("pkt1_rd", rd_count, 2);
    chk("pkt1_abort", abort_count, 0);
    chk("pkt1_idle", busy, 0);

    // UART held busy for 100 cycles mid-packet
    base = n_bytes;
    push(16'hABCD);
    push(16'hEF01);
    enable = 1'b1;
    wait_bytes(base + 3);
    enable = 1'b0;
    force_busy = 1'b1;
    held_nb = n_bytes;
    held_data = txData;
    repeat (100) @(negedge clk40M);
    chk("hold_nbytes", n_bytes, held_nb);
    chk("hold_txData", txData, held_data);
    chk("hold_busy", busy, 1);
    force_busy = 1'b0;
    wait_done(2);
    @(negedge clk40M);
    check_pkt("pkt2", base, 7, 64'h0055AAABCDEF0168);

    // FIFO empty 20+ cycles mid-packet, then refilled
    base = n_bytes;
    push(16'h0102);
    enable = 1'b1;
    wait_bytes(base + 4);
    enable = 1'b0;
    repeat (20) @(negedge clk40M);
    push(16'h0304);
    wait_done(3);
    @(negedge clk40M);
    check_pkt("pkt3", base, 7, 64'h0055AA010203040A);
    chk("refill_abort", abort_count, 0);

    // starvation: one pixel only, aborts after 50 starved FETCH cycles
    base = n_bytes;
    aborts_before = abort_count;
    push(16'h0001);
    enable = 1'b1;
    wait_bytes(base + 4);
    enable = 1'b0;
    for (int i = 0; i < 200 && abort_count == aborts_before; i++) @(negedge clk40M);
    chk("starve_abort", abort_count, aborts_before + 1);
    chk("starve_delay", abort_cyc - last_start_cyc, 49);
    repeat (30) @(negedge clk40M);
    check_pkt("pkt4", base, 4, 64'h0000000055AA0001);
    chk("starve_done", done_count, 3);
    chk("starve_idle", busy, 0);

    // reset while waiting in TX_LO, then a clean packet
    base = n_bytes;
    push(16'h1111);
    push(16'h2222);
    enable = 1'b1;
    wait_bytes(base + 3);
    nRst = 1'b0;
    #1;
    chk("mid_rst_txStart", txStart, 0);
    chk("mid_rst_txData", txData, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd", rd, 0);
    push(16'h3333);
    repeat (3) @(negedge clk40M);
    base = n_bytes;
    nRst = 1'b1;
    wait_done(4);
    enable = 1'b0;
    @(negedge clk40M);
    check_pkt("pkt5", base, 7, 64'h0055AA22223333AA);

    chk("no_start_while_busy", viol_busy, 0);
    chk("start_gap", viol_gap, 0);
    chk("rd_legal", viol_rd, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/image_pkt_uart_tx.md
Name: image_pkt_uart_tx

Overview:
- Downstream consumer of the image buffer's async FIFO read port, in the clk40M domain.
- Drains captured 16-bit pixels from the FIFO and frames them into byte packets for the UART transmitter.
- Packet format: header 0x55, 0xAA; then PIXELS_PER_PKT pixels, each sent MSB byte first; then an 8-bit checksum.
- Packets are emitted back-to-back while enabled and data is available.

Parameters:
- PIXELS_PER_PKT, 16, pixels per packet. Range 1..256; matches one 16-pixel capture burst by default.
- TIMEOUT_CYC, 4000, clk40M cycles an in-packet FIFO read may stay starved before the packet is aborted.

Ports:
- clk40M  input  1  system clock, single clock domain.
- nRst  input  1  reset, asynchronous, active-low.
- enable  input  1  level; when high, packets may start. Sampled only in IDLE.
- empty  input  1  FIFO empty flag, clk40M domain.
- rd  output  1  FIFO read strobe, one-cycle pulse.
- fifoOut  input  16  FIFO data, valid on the cycle after rd.
- txBusy  input  1  UART transmitter busy.
- txStart  output  1  one-cycle pulse; launches the byte on txData.
- txData  output  8  byte to transmit; held stable until the next txStart.
- busy  output  1  high in every state except IDLE.
- pktDone  output  1  one-cycle pulse after the checksum byte is launched.
- pktAbort  output  1  one-cycle pulse when a packet is abandoned on timeout.

Behaviour:
- Reset (nRst low, asynchronous): all outputs 0; FSM in IDLE; pixel counter, checksum, timeout counter and guard flag all 0.
- States: IDLE, HDR0, HDR1, FETCH, LATCH, TX_HI, TX_LO, CSUM, DONE.
- Byte-send rule (HDR0, HDR1, TX_HI, TX_LO, CSUM):
  - Send only when txBusy==0 and the guard flag is clear.
  - On send: pulse txStart for 1 cycle, drive txData, set the guard flag, advance state.
  - The guard flag clears the next cycle, so txBusy is never sampled on the cycle right after txStart.
  - A byte launched by one state is never dropped or duplicated.
- IDLE -> HDR0 when enable==1 and empty==0. On entry, clear the checksum and set the pixel counter to 0.
- HDR0 sends 0x55, then goes to HDR1. HDR1 sends 0xAA, then goes to FETCH. Header bytes are excluded from the checksum.
- FETCH:
  - If empty==0: pulse rd for 1 cycle, clear the timeout counter, go to LATCH.
  - Else: increment the timeout counter. At TIMEOUT_CYC-1: pulse pktAbort, go to IDLE, send nothing further (no checksum).
  - rd is never asserted while empty==1 and never on two consecutive cycles.
- LATCH: capture fifoOut into the pixel register (1-cycle read latency), go to TX_HI.
- TX_HI sends pixel[15:8]; TX_LO sends pixel[7:0].
  - Each sent payload byte is added to the 8-bit checksum, mod 256 (carry discarded).
- After TX_LO: if pixel counter == PIXELS_PER_PKT-1, go to CSUM; else increment the counter and go to FETCH.
- CSUM sends the checksum value accumulated before this byte, then goes to DONE.
- DONE: pulse pktDone, go to IDLE. A new packet may start the following cycle.
- enable dropping mid-packet has no effect; the current packet completes.
- Throughput: with txBusy held 0, successive txStart pulses are at least 2 cycles apart.
- Minimum cycles from IDLE exit to the HDR0 txStart: 1.
- nRst asserted mid-packet: immediate return to IDLE with all outputs 0. No partial checksum is sent after release.

Test Plan:
- Minimal packet: PIXELS_PER_PKT=2; FIFO holds 0x1234, 0x00FF; enable=1; UART model busy 10 cycles per byte.
  -> txData sequence 55 AA 12 34 00 FF 45; pktDone pulses once; exactly 2 rd pulses.
- Default packet: 16 pixels 0x0000..0x000F.
  -> 35 bytes; checksum 0x78; busy high from first txStart through pktDone.
- Starvation: 1 pixel in FIFO, no more written; TIMEOUT_CYC=50.
  -> bytes 55 AA 00 01 sent, then pktAbort after 50 starved FETCH cycles; no checksum byte; back in IDLE.
- Late refill: FIFO empty for 20 cycles mid-packet (TIMEOUT_CYC=50), then refilled.
  -> no abort; the packet completes with the correct checksum.
- Handshake: txBusy held high 100 cycles mid-packet.
  -> no txStart while busy; txData stable; no byte lost or repeated. rd is never asserted with empty==1 (assertion).
- Reset mid-TX_LO, then enable with FIFO refilled.
  -> outputs 0 during reset; the next packet starts cleanly with 0x55 and a checksum independent of the aborted packet.
